// File: rtl/object_placer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : object_placer_pkg                                               |
// | Purpose  : Arena geometry, LFSR constants and placer state encoding.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package object_placer_pkg;

  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 8;
  localparam int ARENA_X_MAX = 255;
  localparam int ARENA_Y_MAX = 255;
  localparam int EDGE_MARGIN = 4;

  localparam logic [15:0] LFSR_MASK         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GEN    = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4,
    FAIL   = 3'd5
  } placer_state_t;

  // Right-shifting Galois step: the bit shifted out feeds back through the mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/object_placer_lfsr16.sv
// +----------------------------------------------------------------------------+
// | Module   : lfsr16                                                          |
// | Purpose  : 16-bit Galois LFSR with seed load; a zero seed is substituted.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module lfsr16
  import object_placer_pkg::*;
(
  input  logic        setup_clk,
  input  logic        RESET,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge setup_clk) begin
    if (RESET) begin
      r_q <= LFSR_DEFAULT_SEED;
    end else if (load) begin
      // The all-zero state would lock up the register forever.
      r_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (step) begin
      r_q <= lfsr_next(r_q);
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/register.sv
// +----------------------------------------------------------------------------+
// | Module   : register                                                        |
// | Purpose  : Generic enabled register with synchronous clear.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/object_placer.sv
// +----------------------------------------------------------------------------+
// | Module   : object_placer                                                   |
// | Purpose  : Setup-phase random placement of N_OBJ static objects.           |
// | Options  : PLACER_RETRY_LIMIT_EN enables the per-object retry limit/FAIL.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module object_placer
  import object_placer_pkg::*;
#(
  parameter int N_OBJ = 4
`ifdef PLACER_RETRY_LIMIT_EN
  , parameter int MAX_TRIES = 15
`endif
) (
  input  logic              setup_clk,
  input  logic              RESET,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic              collision,
  output logic              SETUP_PHASE,
  output logic [N_OBJ-1:0]  SET,
  output logic [X_BITS-1:0] place_x,
  output logic [Y_BITS-1:0] place_y,
  output logic [X_BITS-1:0] collide_x,
  output logic [Y_BITS-1:0] collide_y,
  output logic [N_OBJ-1:0]  placed,
  output logic              done,
  output logic              fail
);

  localparam int c_IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

  localparam logic [X_BITS-1:0] c_x_lo = X_BITS'(EDGE_MARGIN);
  localparam logic [X_BITS-1:0] c_x_hi = X_BITS'(ARENA_X_MAX - EDGE_MARGIN);
  localparam logic [Y_BITS-1:0] c_y_lo = Y_BITS'(EDGE_MARGIN);
  localparam logic [Y_BITS-1:0] c_y_hi = Y_BITS'(ARENA_Y_MAX - EDGE_MARGIN);

  placer_state_t      r_state;
  placer_state_t      w_next_state;
  logic [c_IDX_W-1:0] r_idx;
  logic [N_OBJ-1:0]   r_placed;
  logic               r_done;

  logic [15:0]        w_lfsr_q;
  logic [15:0]        w_lfsr_step;
  logic [X_BITS-1:0]  w_next_x;
  logic [Y_BITS-1:0]  w_next_y;
  logic [X_BITS-1:0]  r_cand_x;
  logic [Y_BITS-1:0]  r_cand_y;

  logic w_load;
  logic w_gen;
  logic w_oob;
  logic w_reject;
  logic w_last;
  logic w_limit;

  assign w_load = (r_state == IDLE) && start;
  assign w_gen  = (r_state == GEN);

  lfsr16 u_lfsr (
    .setup_clk (setup_clk),
    .RESET     (RESET),
    .load      (w_load),
    .seed      (seed),
    .step      (w_gen),
    .q         (w_lfsr_q)
  );

  // The candidate is taken from the value the LFSR steps to in GEN.
  assign w_lfsr_step = lfsr_next(w_lfsr_q);
  assign w_next_x    = w_lfsr_step[X_BITS-1:0];
  assign w_next_y    = w_lfsr_step[15 -: Y_BITS];

  register #(.WIDTH(X_BITS)) u_cand_x (
    .clk  (setup_clk),
    .rst  (RESET),
    .i_en (w_gen),
    .i_d  (w_next_x),
    .o_q  (r_cand_x)
  );

  register #(.WIDTH(Y_BITS)) u_cand_y (
    .clk  (setup_clk),
    .rst  (RESET),
    .i_en (w_gen),
    .i_d  (w_next_y),
    .o_q  (r_cand_y)
  );

  assign w_oob    = (r_cand_x < c_x_lo) || (r_cand_x > c_x_hi) ||
                    (r_cand_y < c_y_lo) || (r_cand_y > c_y_hi);
  assign w_reject = collision || w_oob;
  assign w_last   = (r_idx == c_IDX_W'(N_OBJ - 1));

`ifdef PLACER_RETRY_LIMIT_EN
  localparam int c_TRY_W = $clog2(MAX_TRIES + 1);

  logic [c_TRY_W-1:0] r_tries;
  logic               r_fail;

  assign w_limit = (r_tries == c_TRY_W'(MAX_TRIES - 1));

  always_ff @(posedge setup_clk) begin
    if (RESET) begin
      r_tries <= '0;
      r_fail  <= 1'b0;
    end else if (w_load) begin
      r_tries <= '0;
      r_fail  <= 1'b0;
    end else if (r_state == COMMIT) begin
      r_tries <= '0;
    end else if ((r_state == CHECK) && w_reject) begin
      if (w_limit) begin
        r_fail <= 1'b1;
      end
      if (r_tries != c_TRY_W'(MAX_TRIES)) begin
        r_tries <= r_tries + c_TRY_W'(1);
      end
    end
  end

  assign fail = r_fail;
`else
  assign w_limit = 1'b0;
  assign fail    = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = GEN;
      GEN:     w_next_state = CHECK;
      CHECK: begin
        if (w_reject) begin
          w_next_state = w_limit ? FAIL : GEN;
        end else begin
          w_next_state = COMMIT;
        end
      end
      COMMIT:  w_next_state = w_last ? DONE : GEN;
      DONE:    w_next_state = IDLE;
      FAIL:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge setup_clk) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_placed <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_idx    <= '0;
        r_placed <= '0;
        r_done   <= 1'b0;
      end else if (r_state == COMMIT) begin
        r_placed[r_idx] <= 1'b1;
        if (w_last) begin
          r_done <= 1'b1;
        end else begin
          r_idx <= r_idx + c_IDX_W'(1);
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < N_OBJ; k++) begin : g_set
      assign SET[k] = (r_state == COMMIT) && (r_idx == c_IDX_W'(k));
    end
  endgenerate

  assign SETUP_PHASE = (r_state == GEN) || (r_state == CHECK) || (r_state == COMMIT);
  assign place_x     = r_cand_x;
  assign place_y     = r_cand_y;
  assign collide_x   = r_cand_x;
  assign collide_y   = r_cand_y;
  assign placed      = r_placed;
  assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_object_placer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_object_placer                                                |
// | Purpose  : Directed vectors and corner sequences for object_placer.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_object_placer;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start;
  logic [15:0] seed;
  logic        collision;
  logic        SETUP_PHASE;
  logic [3:0]  SET;
  logic [7:0]  place_x;
  logic [7:0]  place_y;
  logic [7:0]  collide_x;
  logic [7:0]  collide_y;
  logic [3:0]  placed;
  logic        done;
  logic        fail;

  object_placer dut (
    .setup_clk   (clk),
    .RESET       (RESET),
    .start       (start),
    .seed        (seed),
    .collision   (collision),
    .SETUP_PHASE (SETUP_PHASE),
    .SET         (SET),
    .place_x     (place_x),
    .place_y     (place_y),
    .collide_x   (collide_x),
    .collide_y   (collide_y),
    .placed      (placed),
    .done        (done),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0]     seed;
    logic [31:0]     coll;      // bit c: collision driven high in cycle c
    int              pulse;     // cycle of a stray start pulse, -1 for none
    logic [3:0][7:0] set_cyc;
    logic [3:0][7:0] px;
    logic [3:0][7:0] py;
    int              done_cyc;
  } vec_t;

  vec_t vt[5];

  int          seen_set[4];
  logic [7:0]  ox[4];
  logic [7:0]  oy[4];
  int          seen_done;
  logic        saw_set1;

  initial begin
    // seed 1234, clean run, stray start mid-run
    vt[0].seed = 16'h1234; vt[0].coll = 32'h0; vt[0].pulse = 5;
    vt[0].set_cyc = {8'd12, 8'd9, 8'd6, 8'd3};
    vt[0].px = {8'd35, 8'd70, 8'd141, 8'd26};
    vt[0].py = {8'd91, 8'd182, 8'd4, 8'd9};
    vt[0].done_cyc = 13;
    // seed 1234, object 1 collides on its first two checks
    vt[1].seed = 16'h1234; vt[1].coll = 32'h0000_01E0; vt[1].pulse = -1;
    vt[1].set_cyc = {8'd16, 8'd13, 8'd10, 8'd3};
    vt[1].px = {8'd200, 8'd145, 8'd35, 8'd26};
    vt[1].py = {8'd248, 8'd153, 8'd91, 8'd9};
    vt[1].done_cyc = 17;
    // seed 0204: nest rejected twice by bounds (x=2, then y=0)
    vt[2].seed = 16'h0204; vt[2].coll = 32'h0; vt[2].pulse = -1;
    vt[2].set_cyc = {8'd16, 8'd13, 8'd10, 8'd7};
    vt[2].px = {8'd136, 8'd16, 8'd32, 8'd64};
    vt[2].py = {8'd22, 8'd45, 8'd90, 8'd180};
    vt[2].done_cyc = 17;
    // zero seed must behave like ACE1
    vt[3].seed = 16'h0000; vt[3].coll = 32'h0; vt[3].pulse = -1;
    vt[3].set_cyc = {8'd12, 8'd9, 8'd6, 8'd3};
    vt[3].px = {8'd78, 8'd156, 8'd56, 8'd112};
    vt[3].py = {8'd28, 8'd56, 8'd113, 8'd226};
    vt[3].done_cyc = 13;
    vt[4] = vt[3];
    vt[4].seed = 16'hACE1;

    RESET = 1'b1; start = 1'b0; collision = 1'b0; seed = 16'h0;
    tick(); tick();
    chk("rst_phase", SETUP_PHASE, 1'b0);
    chk("rst_set", SET, 4'h0);
    chk("rst_placed", placed, 4'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_fail", fail, 1'b0);
    chk("rst_place_x", place_x, 8'h0);
    chk("rst_collide_y", collide_y, 8'h0);
    RESET = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      seed = vt[v].seed;
      seen_done = -1;
      for (int k = 0; k < 4; k++) begin
        seen_set[k] = -1; ox[k] = 8'h0; oy[k] = 8'h0;
      end
      for (int c = 0; c < 30; c++) begin
        start     = (c == 0) || (c == vt[v].pulse);
        collision = vt[v].coll[c];
        if (c == 1) begin
          chk($sformatf("v%0d_phase_on", v), SETUP_PHASE, 1'b1);
          chk($sformatf("v%0d_done_clr", v), done, 1'b0);
        end
        if (c >= 1) begin
          for (int k = 0; k < 4; k++) begin
            if (SET[k] && seen_set[k] < 0) begin
              seen_set[k] = c; ox[k] = place_x; oy[k] = place_y;
            end
          end
          if (SET != 4'h0) chk($sformatf("v%0d_set_onehot", v), $countones(SET), 1);
          if (done && seen_done < 0) begin
            seen_done = c;
            chk($sformatf("v%0d_phase_off", v), SETUP_PHASE, 1'b0);
          end
        end
        tick();
      end
      start = 1'b0; collision = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d_set%0d_cyc", v, k), seen_set[k], vt[v].set_cyc[k]);
        chk($sformatf("v%0d_x%0d", v, k), ox[k], vt[v].px[k]);
        chk($sformatf("v%0d_y%0d", v, k), oy[k], vt[v].py[k]);
      end
      chk($sformatf("v%0d_done_cyc", v), seen_done, vt[v].done_cyc);
      chk($sformatf("v%0d_placed", v), placed, 4'hF);
      chk($sformatf("v%0d_done_sticky", v), done, 1'b1);
      chk($sformatf("v%0d_fail", v), fail, 1'b0);
    end

    // Collision held after the nest commits: retry limit or endless search.
    seed = 16'h1234; saw_set1 = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      start     = (c == 0);
      collision = (c >= 4);
      if (c >= 1 && SET[1]) saw_set1 = 1'b1;
`ifdef PLACER_RETRY_LIMIT_EN
      if (c == 33) chk("lim_fail_early", fail, 1'b0);
      if (c == 34) begin
        chk("lim_fail", fail, 1'b1);
        chk("lim_phase_off", SETUP_PHASE, 1'b0);
      end
`else
      if (c == 40) begin
        chk("nolim_fail", fail, 1'b0);
        chk("nolim_phase", SETUP_PHASE, 1'b1);
      end
`endif
      tick();
    end
    start = 1'b0; collision = 1'b0;
    chk("lim_no_set1", saw_set1, 1'b0);
    chk("lim_placed", placed, 4'b0001);
    chk("lim_done", done, 1'b0);
    RESET = 1'b1; tick(); RESET = 1'b0; tick();

    // Reset during object 2's CHECK, then restart from the nest.
    seed = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_placed", placed, 4'b0011);
    chk("mid_collide_x", collide_x, 8'd70);
    RESET = 1'b1;
    tick();
    chk("mid_rst_set", SET, 4'h0);
    chk("mid_rst_placed", placed, 4'h0);
    chk("mid_rst_phase", SETUP_PHASE, 1'b0);
    chk("mid_rst_place_x", place_x, 8'h0);
    chk("mid_rst_place_y", place_y, 8'h0);
    chk("mid_rst_collide_x", collide_x, 8'h0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_fail", fail, 1'b0);
    RESET = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("re_collide_x", collide_x, 8'd26);
    chk("re_collide_y", collide_y, 8'd9);
    tick();
    chk("re_set", SET, 4'b0001);
    chk("re_place_x", place_x, 8'd26);
    chk("re_place_y", place_y, 8'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
